// File: rtl/dmem_master.sv
// dmem_master: MEM-stage initiator turning CPU loads/stores into one word-aligned, byte-strobed req/ack access.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module dmem_master #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned WAIT_LIMIT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [2:0]        size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       data_i,
    output logic [31:0]       data_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_wstrb_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);
    localparam int unsigned CNT_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       size_q;
    logic [1:0]       lane_q;
    logic             req_any, timeout;
    logic             is_byte, is_half, is_word;
    logic [1:0]       lane;
    logic [3:0]       wstrb;
    logic [31:0]      wdata;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;
`ifdef MISALIGN_TRAP_EN
    logic             misalign;
`endif

    // Request decode: low address bits are dropped to the natural alignment of the access size.
    always_comb begin
        req_any = memread_i | memwrite_i;
        is_byte = (size_i == 3'b000) || (size_i == 3'b100);
        is_half = (size_i == 3'b001) || (size_i == 3'b101);
        is_word = !is_byte && !is_half;
        lane    = is_byte ? addr_i[1:0] : (is_half ? {addr_i[1], 1'b0} : 2'b00);
        wstrb   = 4'b0000;
        if (memwrite_i) begin
            if (is_byte)      wstrb = 4'b0001 << lane;
            else if (is_half) wstrb = 4'b0011 << lane;
            else              wstrb = 4'b1111;
        end
        if (is_byte)      wdata = {4{data_i[7:0]}};
        else if (is_half) wdata = {2{data_i[15:0]}};
        else              wdata = data_i;
`ifdef MISALIGN_TRAP_EN
        misalign = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
`endif
    end

    always_comb begin
        rd_byte = mem_rdata_i[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (size_q)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_val = {24'h000000, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_val = {16'h0000, rd_half};
            default: load_val = mem_rdata_i;
        endcase
    end

    always_comb begin
        state_next = state;
        stall_o    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                stall_o = req_any;
                if (req_any) begin
`ifdef MISALIGN_TRAP_EN
                    state_next = misalign ? DONE : REQ;
`else
                    state_next = REQ;
`endif
                end
            end
            REQ: begin
                stall_o = 1'b1;
                if (mem_ack_i) begin
                    state_next = DONE;
                end else if (wait_cnt == CNT_W'(WAIT_LIMIT - 1)) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            err_o       <= 1'b0;
            mem_addr_o  <= '0;
            mem_wstrb_o <= '0;
            mem_wdata_o <= '0;
            data_o      <= '0;
            wait_cnt    <= '0;
            size_q      <= '0;
            lane_q      <= '0;
        end else begin
            state <= state_next;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
`ifdef MISALIGN_TRAP_EN
                        if (misalign) begin
                            err_o  <= 1'b1;
                            data_o <= '0;
                        end else
`endif
                        begin
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= memwrite_i;
                            mem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            mem_wstrb_o <= wstrb;
                            mem_wdata_o <= wdata;
                            size_q      <= size_i;
                            lane_q      <= lane;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        wait_cnt  <= '0;
                        data_o    <= mem_we_o ? 32'h0 : load_val;
                    end else if (timeout) begin
                        mem_req_o <= 1'b0;
                        wait_cnt  <= '0;
                        err_o     <= 1'b1;
                        data_o    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
